// File: rtl/counter_pkg.sv
// counter_pkg: shared types and parameter legality helpers for the up/down counter family.
package counter_pkg;
    typedef enum logic {CNT_WRAP = 1'b0, CNT_SAT = 1'b1} cnt_mode_e;
    localparam int DEFAULT_WIDTH = 4;
    localparam int MIN_WIDTH = 2;
    localparam int MAX_WIDTH = 31;
    function automatic bit params_ok(input int width, input longint max_val);
        return width >= MIN_WIDTH && width <= MAX_WIDTH && max_val >= 1 &&
               max_val <= (longint'(1) << width) - 1;
    endfunction
endpackage

// File: rtl/counter_step_alu.sv
// counter_step_alu: combinational next-count for one enabled step, with boundary crossing detection.
module counter_step_alu
    import counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] i_count,
    input  logic [WIDTH-1:0] i_step,
    input  logic             i_up_down,
    input  logic [WIDTH-1:0] i_max_val,
    input  cnt_mode_e        i_mode,
    output logic [WIDTH-1:0] o_next_count,
    output logic             o_crossed_up,
    output logic             o_crossed_down
);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    logic [WIDTH:0]   w_sum;
    logic             w_over;
    logic             w_under;
    logic [WIDTH-1:0] w_up_val;
    logic [WIDTH-1:0] w_dn_val;
    assign w_sum   = {1'b0, i_count} + {1'b0, i_step};
    assign w_over  = w_sum > {1'b0, i_max_val};
    assign w_under = i_step > i_count;
    // Wrapped results always land in 0..max, so modular WIDTH-bit arithmetic is exact here.
    assign w_up_val = w_over ? ((i_mode == CNT_SAT) ? i_max_val : i_count + i_step - i_max_val - ONE)
                             : w_sum[WIDTH-1:0];
    assign w_dn_val = w_under ? ((i_mode == CNT_SAT) ? '0 : i_count - i_step + i_max_val + ONE)
                              : i_count - i_step;
    always_comb begin
        o_next_count   = i_up_down ? w_up_val : w_dn_val;
        o_crossed_up   = i_up_down & w_over;
        o_crossed_down = ~i_up_down & w_under;
    end
endmodule

// File: rtl/param_up_down_counter.sv
// param_up_down_counter: up/down counter with configurable modulus, step, wrap/saturate and sticky boundary flags.
module param_up_down_counter
    import counter_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int MAX_VAL  = (1 << WIDTH) - 1,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_value,
    input  logic             en,
    input  logic             up_down,
    input  logic [WIDTH-1:0] step,
    output logic [WIDTH-1:0] count,
    output logic             at_zero,
    output logic             at_max,
    output logic             wrap_pulse,
    output logic             ovf_sticky,
    output logic             udf_sticky
);
    localparam logic [WIDTH-1:0] MAX  = WIDTH'(MAX_VAL);
    localparam cnt_mode_e        MODE = SATURATE ? CNT_SAT : CNT_WRAP;

    if (!params_ok(WIDTH, MAX_VAL)) begin : g_bad_params
        $error("param_up_down_counter: need WIDTH >= 2 and 1 <= MAX_VAL <= 2**WIDTH-1");
    end

    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    logic             r_ovf;
    logic             r_udf;
    logic [WIDTH-1:0] w_step;
    logic [WIDTH-1:0] w_load;
    logic [WIDTH-1:0] w_next;
    logic             w_up;
    logic             w_down;

    assign w_step = (step > MAX) ? MAX : step;
    assign w_load = (load_value > MAX) ? MAX : load_value;

    counter_step_alu #(.WIDTH(WIDTH)) u_alu (
        .i_count       (r_count),
        .i_step        (w_step),
        .i_up_down     (up_down),
        .i_max_val     (MAX),
        .i_mode        (MODE),
        .o_next_count  (w_next),
        .o_crossed_up  (w_up),
        .o_crossed_down(w_down)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_wrap  <= 1'b0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else if (clr) begin
            r_count <= '0;
            r_wrap  <= 1'b0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else if (load_en) begin
            r_count <= w_load;
            r_wrap  <= 1'b0;
        end else if (en) begin
            r_count <= w_next;
            r_wrap  <= w_up | w_down;
            r_ovf   <= r_ovf | w_up;
            r_udf   <= r_udf | w_down;
        end else begin
            r_wrap  <= 1'b0;
        end
    end

    assign count      = r_count;
    assign at_zero    = r_count == '0;
    assign at_max     = r_count == MAX;
    assign wrap_pulse = r_wrap;
    assign ovf_sticky = r_ovf;
    assign udf_sticky = r_udf;
endmodule

// File: tb/tb_param_up_down_counter.sv
// tb_param_up_down_counter: three counter configurations driven in lockstep, checked by a queue-based scoreboard.
module tb_param_up_down_counter;
    logic clk = 1'b0;
    logic rst = 1'b1, clr = 1'b0, load_en = 1'b0, en = 1'b0, up_down = 1'b1;
    logic [4:0] load_value = '0, step = '0;
    logic [3:0] count_a;
    logic [4:0] count_b, count_c;
    logic [2:0] az, am, wp, ov, ud;

    always #5 clk = ~clk;

    param_up_down_counter #(.WIDTH(4), .MAX_VAL(15), .SATURATE(1'b0)) dut_a (
        .clk(clk), .rst(rst), .clr(clr), .load_en(load_en), .load_value(load_value[3:0]),
        .en(en), .up_down(up_down), .step(step[3:0]), .count(count_a), .at_zero(az[0]),
        .at_max(am[0]), .wrap_pulse(wp[0]), .ovf_sticky(ov[0]), .udf_sticky(ud[0]));
    param_up_down_counter #(.WIDTH(5), .MAX_VAL(9), .SATURATE(1'b0)) dut_b (
        .clk(clk), .rst(rst), .clr(clr), .load_en(load_en), .load_value(load_value),
        .en(en), .up_down(up_down), .step(step), .count(count_b), .at_zero(az[1]),
        .at_max(am[1]), .wrap_pulse(wp[1]), .ovf_sticky(ov[1]), .udf_sticky(ud[1]));
    param_up_down_counter #(.WIDTH(5), .MAX_VAL(15), .SATURATE(1'b1)) dut_c (
        .clk(clk), .rst(rst), .clr(clr), .load_en(load_en), .load_value(load_value),
        .en(en), .up_down(up_down), .step(step), .count(count_c), .at_zero(az[2]),
        .at_max(am[2]), .wrap_pulse(wp[2]), .ovf_sticky(ov[2]), .udf_sticky(ud[2]));

    int mx[3]  = '{15, 9, 15};
    bit sat[3] = '{1'b0, 1'b0, 1'b1};
    int wd[3]  = '{4, 5, 5};
    int m_cnt[3];
    bit m_w[3], m_o[3], m_u[3];

    typedef struct {int k; int cnt; bit w; bit o; bit u;} exp_t;
    exp_t sb[$];
    int checks = 0, errors = 0;

    function automatic int act_cnt(input int k);
        return (k == 0) ? int'(count_a) : (k == 1) ? int'(count_b) : int'(count_c);
    endfunction

    function automatic void check(input exp_t e, input string tag);
        logic [4:0] act_f, exp_f;
        act_f = {az[e.k], am[e.k], wp[e.k], ov[e.k], ud[e.k]};
        exp_f = {e.cnt == 0, e.cnt == mx[e.k], e.w, e.o, e.u};
        checks += 2;
        if (act_cnt(e.k) != e.cnt) begin
            errors++;
            $display("FAIL %s inst%0d count: got %0d expected %0d at %0t", tag, e.k, act_cnt(e.k), e.cnt, $time);
        end
        if (act_f != exp_f) begin
            errors++;
            $display("FAIL %s inst%0d flags{zero,max,wrap,ovf,udf}: got %b expected %b at %0t", tag, e.k, act_f, exp_f, $time);
        end
    endfunction

    function automatic exp_t snap(input int k);
        exp_t e;
        e.k = k; e.cnt = m_cnt[k]; e.w = m_w[k]; e.o = m_o[k]; e.u = m_u[k];
        return e;
    endfunction

    function automatic void model_tick(input bit r, c, l, input int lv, input bit e, up, input int st);
        for (int k = 0; k < 3; k++) begin
            int mask, s, v;
            mask = (1 << wd[k]) - 1;
            s = st & mask;
            s = (s > mx[k]) ? mx[k] : s;
            v = lv & mask;
            if (r || c) begin
                m_cnt[k] = 0; m_w[k] = 0; m_o[k] = 0; m_u[k] = 0;
            end else if (l) begin
                m_cnt[k] = (v > mx[k]) ? mx[k] : v; m_w[k] = 0;
            end else if (e && up) begin
                m_w[k] = m_cnt[k] + s > mx[k];
                if (m_w[k]) m_o[k] = 1;
                m_cnt[k] = !m_w[k] ? m_cnt[k] + s : sat[k] ? mx[k] : m_cnt[k] + s - (mx[k] + 1);
            end else if (e) begin
                m_w[k] = s > m_cnt[k];
                if (m_w[k]) m_u[k] = 1;
                m_cnt[k] = !m_w[k] ? m_cnt[k] - s : sat[k] ? 0 : m_cnt[k] + (mx[k] + 1) - s;
            end else begin
                m_w[k] = 0;
            end
        end
    endfunction

    task automatic tick(input bit r, c, l, input int lv, input bit e, up, input int st, input bit push = 1'b1);
        @(negedge clk);
        #1;
        rst = r; clr = c; load_en = l; load_value = 5'(lv); en = e; up_down = up; step = 5'(st);
        @(posedge clk);
        model_tick(r, c, l, lv, e, up, st);
        if (push) for (int k = 0; k < 3; k++) sb.push_back(snap(k));
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0) check(sb.pop_front(), "scoreboard");
    end

    initial begin
        tick(1, 0, 0, 0, 0, 1, 0);
        tick(1, 0, 0, 0, 1, 1, 1);
        repeat (16) tick(0, 0, 0, 0, 1, 1, 1);
        tick(0, 1, 0, 0, 0, 1, 0);
        tick(0, 0, 1, 2, 0, 0, 0);
        repeat (2) tick(0, 0, 0, 0, 1, 0, 3);
        tick(0, 0, 1, 14, 0, 1, 0);
        repeat (2) tick(0, 0, 0, 0, 1, 1, 4);
        tick(0, 0, 0, 0, 1, 0, 20);
        tick(0, 1, 1, 10, 1, 1, 1);
        tick(0, 0, 1, 20, 0, 1, 0);
        repeat (5) tick(0, 0, 0, 0, 1, 1, 0);
        repeat (5) tick(0, 0, 0, 0, 0, 1, 5);
        tick(0, 0, 1, 9, 0, 1, 0);
        tick(0, 0, 0, 0, 1, 1, 1, 1'b0);
        #1;
        for (int k = 0; k < 3; k++) check(snap(k), "pre_async_rst");
        #2;
        rst = 1'b1;
        model_tick(1, 0, 0, 0, 0, 1, 0);
        #1;
        for (int k = 0; k < 3; k++) check(snap(k), "async_rst");
        tick(1, 0, 0, 0, 1, 1, 1);
        repeat (3) tick(0, 0, 0, 0, 1, 1, 1);
        repeat (300) begin
            int st;
            st = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 31));
            tick($urandom_range(0, 49) == 0, $urandom_range(0, 24) == 0, $urandom_range(0, 5) == 0,
                 int'($urandom_range(0, 31)), $urandom_range(0, 4) != 0, 1'($urandom_range(0, 1)), st);
        end
        repeat (3) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/param_up_down_counter.md
# param_up_down_counter

Parametrised up/down counter, successor to the fixed 4-bit up/down counter. Adds configurable width and modulus, per-cycle step size, wrap or saturate mode, a synchronous clear, boundary flags and overflow/underflow reporting. Used as a general event/position counter in the datapath and as the DUT for the fork/join-based counter verification suite.

## Interface
- WIDTH, 4: count width in bits, ≥ 2.
- MAX_VAL, 2**WIDTH-1: terminal value; the count range is 0..MAX_VAL; 1 ≤ MAX_VAL ≤ 2**WIDTH-1.
- SATURATE, 0: 0 = wrap modulo MAX_VAL+1; 1 = clamp at 0 / MAX_VAL.

- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- clr  in  1  synchronous clear of count and sticky flags.
- load_en  in  1  synchronous load of load_value.
- load_value  in  WIDTH  value to load.
- en  in  1  count enable.
- up_down  in  1  1 = count up, 0 = count down.
- step  in  WIDTH  magnitude per enabled cycle; 0 = hold.
- count  out  WIDTH  current count.
- at_zero  out  1  count == 0.
- at_max  out  1  count == MAX_VAL.
- wrap_pulse  out  1  one-cycle pulse: previous update crossed a boundary (wrapped or saturated).
- ovf_sticky  out  1  set on any upward boundary crossing; held until clr/rst.
- udf_sticky  out  1  set on any downward boundary crossing; held until clr/rst.

## Operation
- Priority per cycle: rst > clr > load_en > en. Lower-priority inputs are ignored in that cycle.
- rst (async): count=0, wrap_pulse=0, ovf_sticky=0, udf_sticky=0 immediately; at_zero=1, at_max=0.
- clr: count=0, stickies=0, wrap_pulse=0.
- load_en: count = min(load_value, MAX_VAL); wrap_pulse=0; stickies unchanged. No flag is raised by clamping.
- step is clamped to MAX_VAL before use (s = min(step, MAX_VAL)).
- Arithmetic in WIDTH+1 bits, no truncation before comparison.
- Up, en=1: sum = count + s. If sum ≤ MAX_VAL: count=sum. Else crossing: wrap mode count = sum − (MAX_VAL+1); saturate mode count = MAX_VAL; ovf_sticky=1; wrap_pulse=1.
- Down, en=1: if s ≤ count: count = count − s. Else crossing: wrap mode count = count + (MAX_VAL+1) − s; saturate mode count = 0; udf_sticky=1; wrap_pulse=1.
- Saturate mode: at MAX_VAL counting up with s>0 is still a crossing (count holds, pulse fires), and likewise at 0 counting down.
- en=0 or s=0: count holds, wrap_pulse=0.
- Direction change takes effect on the next enabled edge; there is no pipeline to flush.

## Timing
- Inputs sampled on posedge clk; count, wrap_pulse and stickies are registered with 1-cycle latency.
- at_zero/at_max decode the count register directly (glitch-free, same cycle as count).
- wrap_pulse is high for exactly the cycle after the crossing edge and low in every non-crossing cycle, including back-to-back crossings (high each cycle).
- rst assertion mid-count clears outputs without waiting for clk. On rst deassertion, the first update occurs at the next posedge.
- Simultaneous clr and load_en: clr wins and count=0. Simultaneous load_en and en: load wins and no step is applied.

## Structure
- Package counter_pkg: typedef cnt_mode_e {CNT_WRAP, CNT_SAT}; constants for the default width and parameter legality checks.
- Sub-module counter_step_alu (combinational): takes count, s, up_down, MAX_VAL, mode. Returns next_count, crossed_up and crossed_down. The top module holds the registers, priority logic and stickies.
- Elaboration-time assertion on MAX_VAL range and WIDTH ≥ 2.

## Test plan
- Reset and wrap-up, WIDTH=4, MAX_VAL=15, wrap: from rst, en=1, up, step=1 for 16 cycles -> count 1..15 then 0. wrap_pulse is high only on the 16th update, ovf_sticky=1, at_zero=1.
- Mod-10 down, MAX_VAL=9, wrap: load 2, down, step=3 -> count=9 (2+10−3), udf_sticky=1, wrap_pulse for one cycle; next step -> 6, pulse 0.
- Saturate, MAX_VAL=15, SATURATE=1: load 14, up, step=4 -> count=15, ovf_sticky=1. Next cycle -> 15 held, wrap_pulse=1 again. Switch to down, step=20 (clamped to 15) -> 0, udf_sticky=1.
- Priority: in one cycle drive clr=1, load_en=1 (10), en=1 -> count=0, stickies cleared. Next cycle drive load_en=1 (20), MAX_VAL=15 -> count=15, no flag.
- Async reset mid-operation: count=10 counting up, assert rst 3 time units after a posedge -> count=0 before the next edge. Deassert rst -> the first increment gives count=1 at the following posedge.
- Hold: en=1, step=0, and en=0 with step=5, each for 5 cycles -> count unchanged, wrap_pulse=0 throughout.
